// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS transmit port among four
// frame sources; a grant is held until the granted source's last beat handshakes.
module eth_tx_arbiter #(
    parameter real SIM_DELAY = 1.0
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [3:0]  port_en,
    input  logic [63:0] s_axis_data,
    input  logic [7:0]  s_axis_keep,
    input  logic [3:0]  s_axis_last,
    input  logic [3:0]  s_axis_valid,
    output logic [3:0]  s_axis_ready,
    output logic [15:0] m_axis_data,
    output logic [1:0]  m_axis_keep,
    output logic        m_axis_last,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        frame_done,
    output logic [1:0]  frame_done_id,
    output logic [63:0] tx_frame_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_grant_q;
    logic        done_pend_q;
    logic [1:0]  done_pend_id_q;
    logic        frame_done_q;
    logic [1:0]  frame_done_id_q;

    logic [3:0]  req;
    logic        grant_vld_d;
    logic [1:0]  grant_d;
    logic [1:0]  scan_idx;
    logic        last_hs;

    logic [15:0] src_data [4];
    logic [1:0]  src_keep [4];

    // SIM_DELAY only shapes behavioural models; registers here update at the edge.
    if (SIM_DELAY < 0.0) begin : g_neg_sim_delay
    end

    assign req  = s_axis_valid & port_en;
    assign busy = (state_q == BUSY);

    // Scan from last_grant+4 down to last_grant+1 so the nearest requester wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = 2'd0;
        scan_idx    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            scan_idx = last_grant_q + k[1:0];
            if (req[scan_idx]) begin
                grant_vld_d = 1'b1;
                grant_d     = scan_idx;
            end
        end
    end

    assign m_axis_data  = src_data[grant_q];
    assign m_axis_keep  = src_keep[grant_q];
    assign m_axis_last  = s_axis_last[grant_q];
    assign m_axis_valid = busy && s_axis_valid[grant_q];
    assign last_hs      = m_axis_valid && m_axis_ready && m_axis_last;

    assign grant_id      = grant_q;
    assign frame_done    = frame_done_q;
    assign frame_done_id = frame_done_id_q;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q         <= IDLE;
            grant_q         <= 2'd0;
            last_grant_q    <= 2'd3;
            done_pend_q     <= 1'b0;
            done_pend_id_q  <= 2'd0;
            frame_done_q    <= 1'b0;
            frame_done_id_q <= 2'd0;
        end else begin
            // Completion is staged one cycle so the pulse and count land together.
            frame_done_q <= done_pend_q;
            done_pend_q  <= 1'b0;
            if (done_pend_q) begin
                frame_done_id_q <= done_pend_id_q;
            end
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (last_hs) begin
                        state_q        <= IDLE;
                        done_pend_q    <= 1'b1;
                        done_pend_id_q <= grant_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            logic [15:0] cnt_q;

            assign src_data[gi]              = s_axis_data[16*gi +: 16];
            assign src_keep[gi]              = s_axis_keep[2*gi +: 2];
            assign s_axis_ready[gi]          = busy && (grant_q == 2'(gi)) && m_axis_ready;
            assign tx_frame_cnt[16*gi +: 16] = cnt_q;

            always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
                if (!s_axis_aresetn) begin
                    cnt_q <= 16'd0;
                end else if (done_pend_q && (done_pend_id_q == 2'(gi))) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: source queues feed the DUT, a scoreboard of expected
// beats and frame completions is checked at every falling edge.
module tb_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  port_en;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic [3:0]  s_last;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic [15:0] m_data;
    logic [1:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic [1:0]  frame_done_id;
    logic [63:0] tx_frame_cnt;

    always #5 clk = ~clk;

    eth_tx_arbiter dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .port_en        (port_en),
        .s_axis_data    (s_data),
        .s_axis_keep    (s_keep),
        .s_axis_last    (s_last),
        .s_axis_valid   (s_valid),
        .s_axis_ready   (s_ready),
        .m_axis_data    (m_data),
        .m_axis_keep    (m_keep),
        .m_axis_last    (m_last),
        .m_axis_valid   (m_valid),
        .m_axis_ready   (m_ready),
        .busy           (busy),
        .grant_id       (grant_id),
        .frame_done     (frame_done),
        .frame_done_id  (frame_done_id),
        .tx_frame_cnt   (tx_frame_cnt)
    );

    typedef struct {
        logic [1:0]  port;
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
        logic        first;
    } beat_t;

    typedef struct {
        logic [1:0] port;
        int         due;
    } done_t;

    typedef struct {
        logic [3:0] en;
        logic [3:0] req;
        logic       none;
        logic [1:0] exp;
    } arb_vec_t;

    beat_t       src_q [4][$];
    beat_t       exp_q [$];
    done_t       done_q [$];
    logic [15:0] exp_cnt [4];
    logic [3:0]  src_gate;
    logic        mready;
    bit          bp_mode;
    bit          gap_chk;
    int          last_hs_cyc;
    int          cyc;
    int          total;
    int          bad;
    arb_vec_t    vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] p, input logic [15:0] d, input logic [1:0] k,
                                 input logic l, input logic f);
        beat_t b;
        b.port = p; b.data = d; b.keep = k; b.last = l; b.first = f;
        return b;
    endfunction

    task automatic src_frame(input int p, input int n, input logic [7:0] tag, input logic [1:0] lkeep);
        for (int b = 0; b < n; b++)
            src_q[p].push_back(mk(2'(p), {tag, 8'(b)}, (b == n-1) ? lkeep : 2'b11, b == n-1, b == 0));
    endtask

    task automatic exp_frame(input int p, input int n, input logic [7:0] tag, input logic [1:0] lkeep);
        for (int b = 0; b < n; b++)
            exp_q.push_back(mk(2'(p), {tag, 8'(b)}, (b == n-1) ? lkeep : 2'b11, b == n-1, b == 0));
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            if (src_gate[p] && src_q[p].size() > 0) begin
                s_valid[p]         = 1'b1;
                s_data[16*p +: 16] = src_q[p][0].data;
                s_keep[2*p +: 2]   = src_q[p][0].keep;
                s_last[p]          = src_q[p][0].last;
            end else begin
                s_valid[p]         = 1'b0;
                s_data[16*p +: 16] = 16'h0;
                s_keep[2*p +: 2]   = 2'b00;
                s_last[p]          = 1'b0;
            end
        end
        m_ready = mready;
    endtask

    task automatic monitor();
        beat_t e;
        done_t d;
        if (!busy)
            check("idle_quiet", {m_valid, s_ready}, 5'd0);
        else if (exp_q.size() > 0)
            check("ready_mirror", s_ready, m_ready ? (4'd1 << exp_q[0].port) : 4'd0);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL beat_unexpected actual=%0h required=none (cycle %0d)", m_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("beat_port", grant_id, e.port);
                check("beat_data", m_data, e.data);
                check("beat_keep", m_keep, e.keep);
                check("beat_last", m_last, e.last);
                if (gap_chk && e.first && last_hs_cyc >= 0)
                    check("frame_gap", cyc - last_hs_cyc, 2);
                if (e.last) begin
                    last_hs_cyc = cyc;
                    done_q.push_back('{port: e.port, due: cyc + 2});
                end
            end
        end
        if (done_q.size() > 0 && done_q[0].due == cyc) begin
            d = done_q.pop_front();
            exp_cnt[d.port] = exp_cnt[d.port] + 16'd1;
            check("frame_done", frame_done, 1'b1);
            check("frame_done_id", frame_done_id, d.port);
            check("frame_cnt", tx_frame_cnt[16*d.port +: 16], exp_cnt[d.port]);
        end else if (frame_done) begin
            total++; bad++;
            $display("FAIL frame_done_spurious actual=1 required=0 (cycle %0d)", cyc);
        end
    endtask

    // Sample at the falling edge, advance sources just after the rising edge.
    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        cyc++;
        monitor();
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++)
            if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (bp_mode) mready = ~mready;
        drive();
    endtask

    task automatic run_until(input int remaining, input int budget);
        int n = 0;
        while (exp_q.size() > remaining && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > remaining) begin
            total++; bad++;
            $display("FAIL timeout actual=%0d beats_left required=%0d", exp_q.size(), remaining);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || done_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0 || done_q.size() > 0) begin
            total++; bad++;
            $display("FAIL timeout actual=%0d pending required=0", exp_q.size() + done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            exp_cnt[p] = 16'd0;
        end
        exp_q.delete();
        done_q.delete();
        src_gate    = 4'hF;
        port_en     = 4'hF;
        mready      = 1'b1;
        bp_mode     = 1'b0;
        gap_chk     = 1'b0;
        last_hs_cyc = -1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_s_ready", s_ready, 4'd0);
        check("rst_frame_done", {frame_done, frame_done_id}, 3'd0);
        check("rst_cnt", tx_frame_cnt, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vd;
        total = 0;
        bad   = 0;
        cyc   = 0;
        s_data = '0; s_keep = '0; s_last = '0; s_valid = '0; m_ready = 1'b1;

        vecs[0] = '{en: 4'b1111, req: 4'b1111, none: 1'b0, exp: 2'd0};
        vecs[1] = '{en: 4'b1111, req: 4'b1111, none: 1'b0, exp: 2'd1};
        vecs[2] = '{en: 4'b1111, req: 4'b0101, none: 1'b0, exp: 2'd2};
        vecs[3] = '{en: 4'b1111, req: 4'b0011, none: 1'b0, exp: 2'd0};
        vecs[4] = '{en: 4'b1110, req: 4'b1111, none: 1'b0, exp: 2'd1};
        vecs[5] = '{en: 4'b1111, req: 4'b0010, none: 1'b0, exp: 2'd1};
        vecs[6] = '{en: 4'b0111, req: 4'b1000, none: 1'b1, exp: 2'd0};
        vecs[7] = '{en: 4'b1111, req: 4'b1000, none: 1'b0, exp: 2'd3};
        vecs[8] = '{en: 4'b1100, req: 4'b1001, none: 1'b0, exp: 2'd3};
        vecs[9] = '{en: 4'b1111, req: 4'b0110, none: 1'b0, exp: 2'd1};

        // Arbitration table: one-beat offers, losers withdrawn after the grant.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            port_en = vecs[i].en;
            for (int p = 0; p < 4; p++) begin
                vd = {8'hA0 + 8'(i), 4'(p), 4'h0};
                if (vecs[i].req[p]) src_q[p].push_back(mk(2'(p), vd, 2'b11, 1'b1, 1'b1));
            end
            drive();
            step();
            if (vecs[i].none) begin
                check("vec_nogrant", busy, 1'b0);
                step();
                check("vec_nogrant2", busy, 1'b0);
            end else begin
                check("vec_busy", busy, 1'b1);
                check("vec_grant", grant_id, vecs[i].exp);
                vd = {8'hA0 + 8'(i), 2'b00, vecs[i].exp, 4'h0};
                exp_q.push_back(mk(vecs[i].exp, vd, 2'b11, 1'b1, 1'b1));
            end
            for (int p = 0; p < 4; p++)
                if (vecs[i].none || p != int'(vecs[i].exp)) src_q[p].delete();
            drive();
            wait_idle(20);
        end

        // Single source, port 2, 3 beats.
        do_reset();
        src_q[2].push_back(mk(2'd2, 16'h1111, 2'b11, 1'b0, 1'b1));
        src_q[2].push_back(mk(2'd2, 16'h2222, 2'b11, 1'b0, 1'b0));
        src_q[2].push_back(mk(2'd2, 16'h3333, 2'b01, 1'b1, 1'b0));
        exp_q.push_back(mk(2'd2, 16'h1111, 2'b11, 1'b0, 1'b1));
        exp_q.push_back(mk(2'd2, 16'h2222, 2'b11, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd2, 16'h3333, 2'b01, 1'b1, 1'b0));
        drive();
        step();
        check("single_grant", {busy, grant_id}, {1'b1, 2'd2});
        wait_idle(20);
        check("single_cnt", tx_frame_cnt, 64'h0000_0001_0000_0000);

        // Round robin with all ports continuously offering 2-beat frames.
        do_reset();
        gap_chk = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 4; p++) begin
                src_frame(p, 2, {4'(p), 4'(f)}, 2'b10);
                exp_frame(p, 2, {4'(p), 4'(f)}, 2'b10);
            end
        drive();
        wait_idle(60);
        check("rr_cnt", tx_frame_cnt, 64'h0002_0002_0002_0002);

        // Enable mask 1010, then port_en[1] dropped inside port 1's third frame.
        do_reset();
        port_en = 4'b1010;
        src_frame(0, 2, 8'h0F, 2'b11);
        src_frame(2, 2, 8'h2F, 2'b11);
        for (int f = 0; f < 4; f++) src_frame(1, 2, {4'h1, 4'(f)}, 2'b11);
        for (int f = 0; f < 3; f++) src_frame(3, 2, {4'h3, 4'(f)}, 2'b11);
        for (int f = 0; f < 3; f++) begin
            exp_frame(1, 2, {4'h1, 4'(f)}, 2'b11);
            exp_frame(3, 2, {4'h3, 4'(f)}, 2'b11);
        end
        drive();
        run_until(3, 60);
        port_en = 4'b1000;
        drive();
        wait_idle(20);
        repeat (6) step();
        check("mask_no_more_grants", busy, 1'b0);
        check("mask_cnt", tx_frame_cnt, 64'h0003_0000_0003_0000);

        // Backpressure: MAC ready toggles every cycle during a 4-beat frame.
        do_reset();
        src_frame(0, 4, 8'hB0, 2'b01);
        exp_frame(0, 4, 8'hB0, 2'b01);
        bp_mode = 1'b1;
        drive();
        wait_idle(40);
        bp_mode = 1'b0;
        mready  = 1'b1;
        check("bp_cnt", tx_frame_cnt, 64'h0000_0000_0000_0001);

        // Source stalls mid-frame: output waits, nothing is lost.
        src_frame(3, 3, 8'hC3, 2'b11);
        exp_frame(3, 3, 8'hC3, 2'b11);
        drive();
        run_until(2, 20);
        src_gate[3] = 1'b0;
        drive();
        step();
        step();
        check("stall_held", {busy, grant_id, 5'(exp_q.size())}, {1'b1, 2'd3, 5'd2});
        src_gate[3] = 1'b1;
        drive();
        wait_idle(20);

        // Counter wrap on port 0.
        do_reset();
        force dut.g_port[0].cnt_q = 16'hFFFF;
        step();
        release dut.g_port[0].cnt_q;
        step();
        check("wrap_preload", tx_frame_cnt[15:0], 16'hFFFF);
        exp_cnt[0] = 16'hFFFF;
        src_frame(0, 1, 8'hD0, 2'b11);
        exp_frame(0, 1, 8'hD0, 2'b11);
        drive();
        wait_idle(20);
        check("wrap_zero", tx_frame_cnt[15:0], 16'h0000);

        // Reset during beat 2 of a 5-beat frame, then priority restarts at port 0.
        do_reset();
        src_frame(0, 5, 8'hE0, 2'b11);
        exp_frame(0, 5, 8'hE0, 2'b11);
        drive();
        run_until(4, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_s_ready", s_ready, 4'd0);
        check("midrst_busy", busy, 1'b0);
        do_reset();
        for (int p = 2; p >= 0; p--) src_frame(p, 1, {4'hF, 4'(p)}, 2'b11);
        for (int p = 0; p < 3; p++) exp_frame(p, 1, {4'hF, 4'(p)}, 2'b11);
        drive();
        step();
        check("midrst_first_grant", {busy, grant_id}, {1'b1, 2'd0});
        wait_idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
